atm_txn_ctrl: RTL
=================

# atm_txn_ctrl

Transaction sequencer for the ATM vending path: walks one card session through PIN check, amount request, note dispense and card return. Owns the session state registers, retry counter and inactivity timer. Drives the dispenser handshake and the account-balance write-back. Sits between the keypad/card front end and the dispenser and balance store.

## Interface
- `PIN_W`, default 16: PIN width (4 BCD digits).
- `AMT_W`, default 16: amount and balance width, unsigned.
- `MAX_TRIES`, default 3: wrong PINs before the card is retained (≥1).
- `TIMEOUT`, default 1000: inactivity limit in cycles for PIN and AMOUNT (≥2).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `card_in`  in  1  level: card present in slot.
- `pin_valid`  in  1  one-cycle strobe; `pin_code` is valid.
- `pin_code`  in  PIN_W  entered PIN.
- `stored_pin`  in  PIN_W  account PIN, stable while `card_in`=1.
- `amt_valid`  in  1  one-cycle strobe; `amt` is valid.
- `amt`  in  AMT_W  requested amount.
- `balance`  in  AMT_W  current balance, stable while `card_in`=1.
- `disp_req`  out  1  dispense request, level.
- `disp_amt`  out  AMT_W  amount to dispense, held while `disp_req`=1.
- `disp_ack`  in  1  one-cycle dispenser completion.
- `bal_we`  out  1  one-cycle balance write strobe.
- `bal_new`  out  AMT_W  `balance - disp_amt`, valid with `bal_we`.
- `card_eject`  out  1  one-cycle eject pulse.
- `card_retain`  out  1  one-cycle retain pulse.
- `state`  out  3  current state encoding.
- `err_code`  out  3  last error; see Operation.

## Operation
States:
- IDLE=0, PIN=1, AMOUNT=2, DISPENSE=3, EJECT=4, RETAIN=5.

Errors:
- NONE=0, BADPIN=1, LOCKED=2, TIMEOUT=3, INSUFF=4, ABORT=5.

Transitions:
- IDLE: `card_in`=1 → PIN. Clears tries, timer and `err_code`.
- PIN, `pin_valid` and match → AMOUNT. Timer cleared.
- PIN, `pin_valid` and mismatch:
  - tries+1 < MAX_TRIES: stay in PIN; tries increments; err=BADPIN; timer cleared.
  - otherwise: → RETAIN; err=LOCKED.
- AMOUNT, `amt_valid`:
  - `amt`=0 or `amt` > `balance`: → EJECT; err=INSUFF.
  - otherwise: latch `disp_amt`; → DISPENSE.
- PIN/AMOUNT, timer reaches TIMEOUT-1 with no strobe → EJECT; err=TIMEOUT.
- PIN/AMOUNT, `card_in`=0 → IDLE; err=ABORT. Abort has priority over strobes and timeout in the same cycle.
- DISPENSE: `disp_req`=1 until `disp_ack`.
  - On ack: pulse `bal_we` with `bal_new`, then → EJECT.
  - No timeout; `card_in` is ignored.
- EJECT: pulse `card_eject` on the entry cycle only, then wait for `card_in`=0 → IDLE.
- RETAIN: pulse `card_retain` for one cycle, then → IDLE. The retained card is not counted as present; IDLE ignores `card_in` for that one cycle.

Arithmetic:
- `bal_new` is an unsigned subtraction. It cannot underflow because of the AMOUNT check.
- Equality `amt`=`balance` is legal and gives `bal_new`=0.

## Timing
- All outputs are registered.
- Reset values:
  - `state`=IDLE, `err_code`=NONE.
  - `disp_req`=0, `disp_amt`=0, `bal_we`=0, `bal_new`=0, `card_eject`=0, `card_retain`=0.
  - Internal tries=0, timer=0.
- Latencies:
  - Strobe sampled at edge N → new `state` visible after edge N.
  - `disp_req` rises on the edge that enters DISPENSE.
  - `disp_ack` at edge N → `disp_req`=0 and `bal_we`=1 after edge N. `bal_we` returns to 0 one cycle later.
- `disp_ack` outside DISPENSE is ignored.
- A strobe while `disp_req`=1 is ignored.
- Timer:
  - Increments once per cycle in PIN/AMOUNT.
  - Clears on entry to these states and on any accepted strobe.
  - A strobe in the expiry cycle wins over the timeout.
- Reset mid-DISPENSE: `disp_req` drops the next edge and there is no `bal_we`. The dispenser must tolerate a request withdrawn by reset.

## Structure
- `atm_pkg` holds:
  - state and error encodings as localparams or typedefs;
  - shared widths used by the keypad and dispenser blocks.
- One sub-module, `atm_timer`: a TIMEOUT-cycle inactivity counter with `clr`, `en` and `expired` ports, and the same `clk`/`rst_n`.
- The FSM, retry counter and output registers stay in `atm_txn_ctrl`.

## Test plan
Bench parameters: TIMEOUT=16, MAX_TRIES=3, `stored_pin`=16'h1234, `balance`=500.

- Happy path: card in; PIN 1234; `amt`=200; ack 3 cycles after `disp_req` → `disp_amt`=200, `bal_we` with `bal_new`=300, `card_eject` pulse, IDLE after `card_in`=0.
- Bad PIN: wrong PINs 0000 and 1111, then 1234 → err=BADPIN after each miss, then AMOUNT.
- Lockout: three wrong PINs → `card_retain` one pulse, err=LOCKED, IDLE, no `card_eject`.
- Insufficient funds: `amt`=501 → EJECT, err=INSUFF, no `disp_req`. Separately, `amt`=500 → `bal_new`=0.
- Timeout: no input for 16 cycles in AMOUNT → EJECT, err=TIMEOUT. A strobe exactly on the expiry cycle is accepted instead.
- Abort and reset: `card_in`=0 in PIN → IDLE, err=ABORT. `rst_n`=0 during DISPENSE → all outputs at reset values next edge, no `bal_we`.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared encodings and default widths for the ATM transaction path.
// Used by the sequencer, its timer, and the keypad/dispenser blocks around it.
package atm_pkg;

    localparam int PIN_W_DEF = 16;
    localparam int AMT_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PIN      = 3'd1,
        ST_AMOUNT   = 3'd2,
        ST_DISPENSE = 3'd3,
        ST_EJECT    = 3'd4,
        ST_RETAIN   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_BADPIN  = 3'd1,
        ERR_LOCKED  = 3'd2,
        ERR_TIMEOUT = 3'd3,
        ERR_INSUFF  = 3'd4,
        ERR_ABORT   = 3'd5
    } err_t;

endpackage

// File: rtl/atm_timer.sv
// Inactivity counter: expired is high while the count sits at TIMEOUT-1 and en is set.
// clr wins over en; the count never advances past the expiry value while enabled.
module atm_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] r_cnt;
    logic          w_at_limit;

    assign w_at_limit = (r_cnt == TW'(TIMEOUT - 1));
    assign expired    = en && w_at_limit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && !w_at_limit) begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

endmodule

// File: rtl/atm_txn_ctrl.sv
// Card-session sequencer: PIN check, amount request, dispense handshake, card return.
// All outputs registered; a state change becomes visible one edge after its cause.
module atm_txn_ctrl
    import atm_pkg::*;
#(
    parameter int PIN_W     = PIN_W_DEF,
    parameter int AMT_W     = AMT_W_DEF,
    parameter int MAX_TRIES = 3,
    parameter int TIMEOUT   = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             card_in,
    input  logic             pin_valid,
    input  logic [PIN_W-1:0] pin_code,
    input  logic [PIN_W-1:0] stored_pin,
    input  logic             amt_valid,
    input  logic [AMT_W-1:0] amt,
    input  logic [AMT_W-1:0] balance,
    output logic             disp_req,
    output logic [AMT_W-1:0] disp_amt,
    input  logic             disp_ack,
    output logic             bal_we,
    output logic [AMT_W-1:0] bal_new,
    output logic             card_eject,
    output logic             card_retain,
    output logic [2:0]       state,
    output logic [2:0]       err_code
);
    localparam int TRW = $clog2(MAX_TRIES + 1);

    state_t           r_state, w_nxt_state;
    err_t             r_err, w_nxt_err;
    logic [TRW-1:0]   r_tries, w_nxt_tries;
    logic             r_ign_card;
    logic             r_disp_req, r_bal_we, r_card_eject, r_card_retain;
    logic [AMT_W-1:0] r_disp_amt, r_bal_new;
    logic             w_acc, w_ack, w_latch;
    logic             w_tmr_en, w_tmr_clr, w_expired;

    assign w_tmr_en  = (r_state == ST_PIN) || (r_state == ST_AMOUNT);
    assign w_tmr_clr = !w_tmr_en || w_acc;

    atm_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_tmr_clr),
        .en      (w_tmr_en),
        .expired (w_expired)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_err   = r_err;
        w_nxt_tries = r_tries;
        w_acc       = 1'b0;
        w_ack       = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (card_in && !r_ign_card) begin
                    w_nxt_state = ST_PIN;
                    w_nxt_err   = ERR_NONE;
                    w_nxt_tries = '0;
                end
            end
            ST_PIN: begin
                if (!card_in) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_err   = ERR_ABORT;
                end else if (pin_valid) begin
                    w_acc = 1'b1;
                    if (pin_code == stored_pin) begin
                        w_nxt_state = ST_AMOUNT;
                    end else if (int'(r_tries) + 1 < MAX_TRIES) begin
                        w_nxt_tries = r_tries + TRW'(1);
                        w_nxt_err   = ERR_BADPIN;
                    end else begin
                        w_nxt_state = ST_RETAIN;
                        w_nxt_err   = ERR_LOCKED;
                    end
                end else if (w_expired) begin
                    w_nxt_state = ST_EJECT;
                    w_nxt_err   = ERR_TIMEOUT;
                end
            end
            ST_AMOUNT: begin
                if (!card_in) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_err   = ERR_ABORT;
                end else if (amt_valid) begin
                    w_acc = 1'b1;
                    if ((amt == '0) || (amt > balance)) begin
                        w_nxt_state = ST_EJECT;
                        w_nxt_err   = ERR_INSUFF;
                    end else begin
                        w_latch     = 1'b1;
                        w_nxt_state = ST_DISPENSE;
                    end
                end else if (w_expired) begin
                    w_nxt_state = ST_EJECT;
                    w_nxt_err   = ERR_TIMEOUT;
                end
            end
            ST_DISPENSE: begin
                if (disp_ack) begin
                    w_ack       = 1'b1;
                    w_nxt_state = ST_EJECT;
                end
            end
            ST_EJECT: begin
                if (!card_in) w_nxt_state = ST_IDLE;
            end
            ST_RETAIN: w_nxt_state = ST_IDLE;
            default:   w_nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_err         <= ERR_NONE;
            r_tries       <= '0;
            r_ign_card    <= 1'b0;
            r_disp_req    <= 1'b0;
            r_disp_amt    <= '0;
            r_bal_we      <= 1'b0;
            r_bal_new     <= '0;
            r_card_eject  <= 1'b0;
            r_card_retain <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_err         <= w_nxt_err;
            r_tries       <= w_nxt_tries;
            // the retained card stays physically in the slot for one IDLE cycle
            r_ign_card    <= (r_state == ST_RETAIN);
            r_disp_req    <= (w_nxt_state == ST_DISPENSE);
            r_bal_we      <= w_ack;
            r_card_eject  <= (w_nxt_state == ST_EJECT) && (r_state != ST_EJECT);
            r_card_retain <= (w_nxt_state == ST_RETAIN);
            if (w_latch) r_disp_amt <= amt;
            if (w_ack)   r_bal_new  <= balance - r_disp_amt;
        end
    end

    assign state       = r_state;
    assign err_code    = r_err;
    assign disp_req    = r_disp_req;
    assign disp_amt    = r_disp_amt;
    assign bal_we      = r_bal_we;
    assign bal_new     = r_bal_new;
    assign card_eject  = r_card_eject;
    assign card_retain = r_card_retain;

endmodule
